// File: rtl/pipeline_hazard_ctrl_if.sv
// ============================================================================
// Module      : pipeline_hazard_ctrl_if
// Description : Decode-stage hazard inputs and stall/flush/forward controls
//               for the pipeline hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipeline_hazard_ctrl_if #(
   parameter int CNT_WIDTH = 16
);
   logic [4:0]           Rs1D;
   logic [4:0]           Rs2D;
   logic                 UsesRs1D;
   logic                 UsesRs2D;
   logic [4:0]           RdD;
   logic                 RegWriteD;
   logic                 ResultSrcD;
   logic                 PCSrcE;
   logic                 StallF;
   logic                 StallD;
   logic                 FlushD;
   logic                 FlushE;
   logic [1:0]           ForwardAE;
   logic [1:0]           ForwardBE;
   logic                 ForwardAD;
   logic                 ForwardBD;
   logic [CNT_WIDTH-1:0] StallCnt;
   logic [CNT_WIDTH-1:0] FlushCnt;

   modport master (
      output Rs1D, Rs2D, UsesRs1D, UsesRs2D, RdD, RegWriteD, ResultSrcD, PCSrcE,
      input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
      input  ForwardAD, ForwardBD, StallCnt, FlushCnt
   );

   modport slave (
      input  Rs1D, Rs2D, UsesRs1D, UsesRs2D, RdD, RegWriteD, ResultSrcD, PCSrcE,
      output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
      output ForwardAD, ForwardBD, StallCnt, FlushCnt
   );
endinterface

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Five-stage pipeline hazard unit with shadow E/M/W records,
//               stall/flush generation and saturating event counters.
//               Macro HAZARD_FORWARD_EN selects forwarding mode; without it,
//               every RAW hazard is resolved by stalling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl #(
   parameter int CNT_WIDTH = 16
) (
   input  wire logic             clk,
   input  wire logic             rst,
   pipeline_hazard_ctrl_if.slave hz
);

   localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = '1;

   function automatic logic f_match(
      input logic       uses,
      input logic       wr,
      input logic [4:0] rd,
      input logic [4:0] src
   );
      return uses & wr & (rd == src) & (rd != 5'd0);
   endfunction

   logic [4:0]           e_rd_q;
   logic                 e_wr_q;
   logic                 e_ld_q;
   logic [4:0]           m_rd_q;
   logic                 m_wr_q;
   logic [4:0]           w_rd_q;
   logic                 w_wr_q;
   logic [CNT_WIDTH-1:0] stall_cnt_q;
   logic [CNT_WIDTH-1:0] stall_cnt_d;
   logic [CNT_WIDTH-1:0] flush_cnt_q;
   logic [CNT_WIDTH-1:0] flush_cnt_d;

   logic w_match_e1;
   logic w_match_e2;
   logic w_match_w1;
   logic w_match_w2;
   logic w_load_use;
   logic w_hazard;
   logic w_stall_f;
   logic w_stall_d;
   logic w_flush_d;
   logic w_flush_e;

   assign w_match_e1 = f_match(hz.UsesRs1D, e_wr_q, e_rd_q, hz.Rs1D);
   assign w_match_e2 = f_match(hz.UsesRs2D, e_wr_q, e_rd_q, hz.Rs2D);
   assign w_match_w1 = f_match(hz.UsesRs1D, w_wr_q, w_rd_q, hz.Rs1D);
   assign w_match_w2 = f_match(hz.UsesRs2D, w_wr_q, w_rd_q, hz.Rs2D);
   assign w_load_use = e_ld_q & (w_match_e1 | w_match_e2);

`ifdef HAZARD_FORWARD_EN
   // Unused sources are stored as x0 so they can never match a writer.
   logic [4:0] e_rs1_q;
   logic [4:0] e_rs2_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         e_rs1_q <= 5'd0;
         e_rs2_q <= 5'd0;
      end else if (w_flush_e) begin
         e_rs1_q <= 5'd0;
         e_rs2_q <= 5'd0;
      end else begin
         e_rs1_q <= hz.UsesRs1D ? hz.Rs1D : 5'd0;
         e_rs2_q <= hz.UsesRs2D ? hz.Rs2D : 5'd0;
      end
   end

   assign w_hazard = w_load_use;

   always_comb begin
      hz.ForwardAE = 2'b00;
      hz.ForwardBE = 2'b00;
      if (f_match(1'b1, m_wr_q, m_rd_q, e_rs1_q)) begin
         hz.ForwardAE = 2'b10;
      end else if (f_match(1'b1, w_wr_q, w_rd_q, e_rs1_q)) begin
         hz.ForwardAE = 2'b01;
      end
      if (f_match(1'b1, m_wr_q, m_rd_q, e_rs2_q)) begin
         hz.ForwardBE = 2'b10;
      end else if (f_match(1'b1, w_wr_q, w_rd_q, e_rs2_q)) begin
         hz.ForwardBE = 2'b01;
      end
   end

   // Register file has no write-through, so a W-stage write must be bypassed.
   assign hz.ForwardAD = w_match_w1;
   assign hz.ForwardBD = w_match_w2;
`else
   logic w_match_m1;
   logic w_match_m2;

   assign w_match_m1 = f_match(hz.UsesRs1D, m_wr_q, m_rd_q, hz.Rs1D);
   assign w_match_m2 = f_match(hz.UsesRs2D, m_wr_q, m_rd_q, hz.Rs2D);
   assign w_hazard   = w_load_use | w_match_e1 | w_match_e2 |
                       w_match_m1 | w_match_m2 | w_match_w1 | w_match_w2;

   assign hz.ForwardAE = 2'b00;
   assign hz.ForwardBE = 2'b00;
   assign hz.ForwardAD = 1'b0;
   assign hz.ForwardBD = 1'b0;
`endif

   // A redirect discards the stalled instruction, so it overrides any stall.
   always_comb begin
      w_stall_f = 1'b0;
      w_stall_d = 1'b0;
      w_flush_d = 1'b0;
      w_flush_e = 1'b0;
      if (hz.PCSrcE) begin
         w_flush_d = 1'b1;
         w_flush_e = 1'b1;
      end else if (w_hazard) begin
         w_stall_f = 1'b1;
         w_stall_d = 1'b1;
         w_flush_e = 1'b1;
      end
   end

   assign hz.StallF = w_stall_f;
   assign hz.StallD = w_stall_d;
   assign hz.FlushD = w_flush_d;
   assign hz.FlushE = w_flush_e;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         e_rd_q <= 5'd0;
         e_wr_q <= 1'b0;
         e_ld_q <= 1'b0;
         m_rd_q <= 5'd0;
         m_wr_q <= 1'b0;
         w_rd_q <= 5'd0;
         w_wr_q <= 1'b0;
      end else begin
         m_rd_q <= e_rd_q;
         m_wr_q <= e_wr_q;
         w_rd_q <= m_rd_q;
         w_wr_q <= m_wr_q;
         if (w_flush_e) begin
            e_rd_q <= 5'd0;
            e_wr_q <= 1'b0;
            e_ld_q <= 1'b0;
         end else begin
            e_rd_q <= hz.RdD;
            e_wr_q <= hz.RegWriteD;
            e_ld_q <= hz.ResultSrcD;
         end
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (w_stall_d && (stall_cnt_q != C_CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + C_CNT_ONE;
      end
      if (hz.PCSrcE && (flush_cnt_q != C_CNT_MAX)) begin
         flush_cnt_d = flush_cnt_q + C_CNT_ONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign hz.StallCnt = stall_cnt_q;
   assign hz.FlushCnt = flush_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Directed and randomized bench for pipeline_hazard_ctrl with an
//               instruction-level pipeline reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;

   localparam int TB_CNT  = 4;
   localparam int CNT_MAX = (1 << TB_CNT) - 1;
`ifdef HAZARD_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pipeline_hazard_ctrl_if #(.CNT_WIDTH(TB_CNT)) hz ();
   pipeline_hazard_ctrl #(.CNT_WIDTH(TB_CNT)) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz)
   );

   typedef struct {
      int rd;
      int rs1;
      int rs2;
      bit wr;
      bit ld;
      bit u1;
      bit u2;
      bit pc;
   } instr_t;

   instr_t pipe [3];   // 0 = Execute, 1 = Memory, 2 = Writeback
   instr_t d_in;
   int     m_scnt;
   int     m_fcnt;
   int     n_checks = 0;
   int     n_pass   = 0;
   int     obs_stalls;
   bit     ex_stallD;
   bit     ex_flushD;
   bit     ex_flushE;
   int     ex_fae;
   int     ex_fbe;
   bit     ex_fad;
   bit     ex_fbd;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks = n_checks + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic bit writes_to(input instr_t p, input bit uses, input int src);
      return uses && p.wr && (p.rd != 0) && (p.rd == src);
   endfunction

   task automatic model_clear();
      instr_t b;
      b = '{default: 0};
      for (int k = 0; k < 3; k++) pipe[k] = b;
      m_scnt = 0;
      m_fcnt = 0;
   endtask

   task automatic model_eval();
      bit     any;
      instr_t e;
      e   = pipe[0];
      any = e.ld && (writes_to(e, d_in.u1, d_in.rs1) || writes_to(e, d_in.u2, d_in.rs2));
      ex_fae = 0;
      ex_fbe = 0;
      ex_fad = 1'b0;
      ex_fbd = 1'b0;
      if (FWD) begin
         ex_fae = writes_to(pipe[1], e.u1, e.rs1) ? 2 : (writes_to(pipe[2], e.u1, e.rs1) ? 1 : 0);
         ex_fbe = writes_to(pipe[1], e.u2, e.rs2) ? 2 : (writes_to(pipe[2], e.u2, e.rs2) ? 1 : 0);
         ex_fad = writes_to(pipe[2], d_in.u1, d_in.rs1);
         ex_fbd = writes_to(pipe[2], d_in.u2, d_in.rs2);
      end else begin
         for (int k = 0; k < 3; k++)
            if (writes_to(pipe[k], d_in.u1, d_in.rs1) || writes_to(pipe[k], d_in.u2, d_in.rs2))
               any = 1'b1;
      end
      ex_stallD = !d_in.pc && any;
      ex_flushD = d_in.pc;
      ex_flushE = d_in.pc || any;
   endtask

   task automatic model_edge();
      instr_t b;
      b = '{default: 0};
      if (rst) begin
         model_clear();
      end else begin
         if (ex_stallD && m_scnt < CNT_MAX) m_scnt++;
         if (d_in.pc && m_fcnt < CNT_MAX) m_fcnt++;
         pipe[2] = pipe[1];
         pipe[1] = pipe[0];
         pipe[0] = ex_flushE ? b : d_in;
      end
   endtask

   task automatic setd(input int rs1, input bit u1, input int rs2, input bit u2,
                       input int rd, input bit wr, input bit ld, input bit pc);
      d_in = '{rd: rd, rs1: rs1, rs2: rs2, wr: wr, ld: ld, u1: u1, u2: u2, pc: pc};
      hz.Rs1D       = 5'(rs1);
      hz.UsesRs1D   = u1;
      hz.Rs2D       = 5'(rs2);
      hz.UsesRs2D   = u2;
      hz.RdD        = 5'(rd);
      hz.RegWriteD  = wr;
      hz.ResultSrcD = ld;
      hz.PCSrcE     = pc;
   endtask

   task automatic idle();
      setd(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic settle();
      #2;
      model_eval();
      chk("StallF",    32'(hz.StallF),    32'(ex_stallD));
      chk("StallD",    32'(hz.StallD),    32'(ex_stallD));
      chk("FlushD",    32'(hz.FlushD),    32'(ex_flushD));
      chk("FlushE",    32'(hz.FlushE),    32'(ex_flushE));
      chk("ForwardAE", 32'(hz.ForwardAE), 32'(ex_fae));
      chk("ForwardBE", 32'(hz.ForwardBE), 32'(ex_fbe));
      chk("ForwardAD", 32'(hz.ForwardAD), 32'(ex_fad));
      chk("ForwardBD", 32'(hz.ForwardBD), 32'(ex_fbd));
      chk("StallCnt",  32'(hz.StallCnt),  32'(m_scnt));
      chk("FlushCnt",  32'(hz.FlushCnt),  32'(m_fcnt));
      if (hz.StallD === 1'b1) obs_stalls++;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic step();
      settle();
      tick();
   endtask

   task automatic idles(input int n);
      idle();
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic hold_while_stalled();
      int n;
      n = 0;
      while (ex_stallD && n < 6) begin
         tick();
         settle();
         n++;
      end
      tick();
   endtask

   initial begin
      // Reset state
      model_clear();
      idle();
      settle();
      chk("rst_StallCnt", 32'(hz.StallCnt), 32'd0);
      tick();
      rst = 1'b0;
      idles(3);

      // Load x5 then add x6,x5,x7
      setd(1, 1, 0, 0, 5, 1, 1, 0);
      step();
      setd(5, 1, 7, 1, 6, 1, 0, 0);
      obs_stalls = 0;
      settle();
      hold_while_stalled();
      chk("A_stall_cycles", 32'(obs_stalls), FWD ? 32'd1 : 32'd3);
      idle();
      settle();
      chk("A_ForwardAE", 32'(hz.ForwardAE), FWD ? 32'd1 : 32'd0);
      chk("A_StallCnt",  32'(hz.StallCnt),  FWD ? 32'd1 : 32'd3);
      tick();
      idles(3);

      // add x5 then sub x8,x5,x5
      setd(1, 1, 2, 1, 5, 1, 0, 0);
      step();
      setd(5, 1, 5, 1, 8, 1, 0, 0);
      obs_stalls = 0;
      settle();
      hold_while_stalled();
      chk("B_stall_cycles", 32'(obs_stalls), FWD ? 32'd0 : 32'd3);
      idle();
      settle();
      chk("B_ForwardAE", 32'(hz.ForwardAE), FWD ? 32'd2 : 32'd0);
      chk("B_ForwardBE", 32'(hz.ForwardBE), FWD ? 32'd2 : 32'd0);
      chk("B_StallCnt",  32'(hz.StallCnt),  FWD ? 32'd1 : 32'd6);
      tick();
      idles(3);

      // Redirect in the same cycle as a load-use match
      setd(1, 1, 0, 0, 5, 1, 1, 0);
      step();
      setd(5, 1, 7, 1, 6, 1, 0, 1);
      settle();
      chk("C_FlushD", 32'(hz.FlushD), 32'd1);
      chk("C_FlushE", 32'(hz.FlushE), 32'd1);
      chk("C_StallF", 32'(hz.StallF), 32'd0);
      chk("C_StallD", 32'(hz.StallD), 32'd0);
      tick();
      idle();
      settle();
      chk("C_FlushCnt", 32'(hz.FlushCnt), 32'd1);
      chk("C_StallCnt", 32'(hz.StallCnt), FWD ? 32'd1 : 32'd6);
      tick();
      idles(3);

      // Back-to-back write and read of x0
      setd(0, 0, 0, 0, 0, 1, 1, 0);
      step();
      setd(0, 1, 0, 1, 0, 1, 1, 0);
      settle();
      chk("D_no_stall", 32'(hz.StallD), 32'd0);
      tick();
      idle();
      settle();
      chk("D_no_fwdAE", 32'(hz.ForwardAE), 32'd0);
      chk("D_no_fwdBE", 32'(hz.ForwardBE), 32'd0);
      tick();
      idles(3);

      // Randomized traffic on a small register window
      for (int i = 0; i < 300; i++) begin
         setd(int'($urandom_range(0, 3)), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom),
              int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
         step();
      end
      idles(3);

      // Counter saturation: at least 2^CNT_WIDTH+5 stall cycles
      setd(5, 1, 0, 0, 5, 1, 1, 0);
      obs_stalls = 0;
      for (int n = 0; n < 200 && obs_stalls < CNT_MAX + 6; n++) step();
      chk("F_stalls_reached", 32'(obs_stalls >= CNT_MAX + 6), 32'd1);
      idle();
      settle();
      chk("F_StallCnt_sat", 32'(hz.StallCnt), 32'(CNT_MAX));
      tick();
      idles(3);

      // Reset asserted in the middle of a stall
      setd(1, 1, 0, 0, 5, 1, 1, 0);
      step();
      setd(5, 1, 7, 1, 6, 1, 0, 0);
      settle();
      chk("G_stall_before_rst", 32'(hz.StallD), 32'd1);
      #1 rst = 1'b1;
      model_clear();
      #1;
      chk("G_rst_StallF",   32'(hz.StallF),   32'd0);
      chk("G_rst_StallD",   32'(hz.StallD),   32'd0);
      chk("G_rst_FlushD",   32'(hz.FlushD),   32'd0);
      chk("G_rst_FlushE",   32'(hz.FlushE),   32'd0);
      chk("G_rst_FwdAE",    32'(hz.ForwardAE), 32'd0);
      chk("G_rst_FwdBE",    32'(hz.ForwardBE), 32'd0);
      chk("G_rst_FwdAD",    32'(hz.ForwardAD), 32'd0);
      chk("G_rst_FwdBD",    32'(hz.ForwardBD), 32'd0);
      chk("G_rst_StallCnt", 32'(hz.StallCnt), 32'd0);
      chk("G_rst_FlushCnt", 32'(hz.FlushCnt), 32'd0);
      tick();
      settle();
      rst = 1'b0;
      tick();
      idles(3);
      chk("G_post_StallCnt", 32'(hz.StallCnt), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clk and rst.
REQ-002 Parameter CNT_WIDTH, default 16, SHALL set the width of the stall and flush event counters.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 Rs1D, Rs2D  input  5  source register indices of the instruction in Decode.
REQ-006 UsesRs1D, UsesRs2D  input  1  instruction in Decode reads Rs1D / Rs2D.
REQ-007 RdD  input  5  destination register of the instruction in Decode.
REQ-008 RegWriteD  input  1  instruction in Decode writes RdD.
REQ-009 ResultSrcD  input  1  instruction in Decode is a load (result taken from data memory).
REQ-010 PCSrcE  input  1  taken branch or jump resolved in Execute.
REQ-011 StallF, StallD  output  1  hold the PC and the F/D register.
REQ-012 FlushD, FlushE  output  1  clear the F/D and D/E registers to a bubble.
REQ-013 ForwardAE, ForwardBE  output  2  ALU operand select: 00 register, 10 M-stage ALU result, 01 W-stage result.
REQ-014 ForwardAD, ForwardBD  output  1  substitute the W-stage result for the register-file read in Decode.
REQ-015 StallCnt, FlushCnt  output  CNT_WIDTH  saturating event counters.

Function
REQ-016 The block SHALL keep shadow E, M and W stage records {Rd, RegWrite, Load, Rs1, Rs2}; the E record is loaded from the D inputs on each clock edge, the M record from E, and the W record from M.
REQ-017 When FlushE=1, the E record SHALL be loaded with RegWrite=0 and Load=0 (a bubble); M and W SHALL still advance.
REQ-018 A source register SHALL "match" a stage only when the corresponding Uses bit is 1, the stage has RegWrite=1, Rd equals the source, and Rd is not 0.
REQ-019 Load-use stall: when Decode matches E and E.Load=1, the block SHALL assert StallF=StallD=FlushE=1 for that cycle.
REQ-020 Forwarding SHALL be combinational: ForwardAE/BE=10 on an E-record Rs1/Rs2 match with M, else 01 on a match with W, else 00; M SHALL take priority over W.
REQ-021 ForwardAD/BD SHALL be 1 when Rs1D/Rs2D matches W, because the register file does not return a value written in the same cycle.
REQ-022 Redirect: when PCSrcE=1, the block SHALL assert FlushD=FlushE=1 and force StallF=StallD=0; a redirect SHALL override any stall in the same cycle.
REQ-023 With no hazard and no redirect, all control outputs SHALL be 0.
REQ-024 StallCnt SHALL increment on each cycle with StallD=1, FlushCnt on each cycle with PCSrcE=1; both SHALL saturate at all-ones and never wrap.
REQ-025 Outputs derived from the shadow records SHALL be valid in the same cycle as the inputs, with no added latency.

Reset
REQ-026 While rst=1, every shadow record SHALL hold RegWrite=0, Load=0 and Rd=0, and both counters SHALL be 0.
REQ-027 After reset, with the D inputs inactive, every output SHALL be 0.
REQ-028 A reset asserted mid-stall SHALL end the stall immediately, and no counter increment SHALL occur on that edge.

Configuration
REQ-029 Macro HAZARD_FORWARD_EN SHALL select the hazard-resolution mode.
REQ-030 With HAZARD_FORWARD_EN defined, the block SHALL implement REQ-019 to REQ-021 as written.
REQ-031 Without HAZARD_FORWARD_EN, ForwardAE/BE SHALL be 00 and ForwardAD/BD SHALL be 0, held constant.
REQ-032 Without HAZARD_FORWARD_EN, any Decode match with E, M or W SHALL assert StallF=StallD=FlushE=1, and the stall SHALL hold until no match remains (at most 3 cycles).

Verification
REQ-033 Load x5, then add x6,x5,x7 with forwarding: exactly 1 cycle of StallF/StallD/FlushE=1, then ForwardAE=01, and StallCnt=1.
REQ-034 add x5, then sub x8,x5,x5 with forwarding: no stall; ForwardAE=ForwardBE=10 in the sub's E cycle.
REQ-035 The same add/sub pair without HAZARD_FORWARD_EN: 3 consecutive stall cycles, forward outputs 0, StallCnt=3.
REQ-036 PCSrcE=1 in the same cycle as a load-use match: FlushD=FlushE=1, StallF=StallD=0, FlushCnt=1, StallCnt unchanged.
REQ-037 Writes and reads of x0 back-to-back: no stall and no forwarding; 2^CNT_WIDTH+5 stall cycles leave StallCnt at all-ones.
REQ-038 rst asserted during a non-forwarding stall: all outputs 0 and counters 0 within the reset cycle.
